// File: rtl/boc_prn_nco_gen.sv
// boc_prn_nco_gen: NCO-driven BOC spreading-code generator for one correlator
// channel of the B1 receiver.
//
// A phase accumulator advances a chip counter. The counter plus a code offset
// addresses an external async-read code ROM. The returned chip is registered
// as the prompt chip, XORed with a square subcarrier, and fed into a
// half-chip-spaced tap delay line.
//
// Ports:
//   rx_clk, rx_rst_n   clock (rising edge) / async active-low reset
//   rx_en              clock enable for every register (rx_load bypasses it)
//   rx_fcw             code-rate frequency control word
//   rx_mode            0 = track (fixed offset), 1 = acquisition (step per epoch)
//   rx_load            restart at chip 0 with offset rx_start_idx
//   rx_start_idx       offset applied by rx_load
//   rx_rom_data        ROM[tx_rom_addr], same cycle
//   tx_rom_addr        registered code index (chip_cnt + offset) mod CODE_LEN
//   tx_chip, tx_boc    prompt chip / chip XOR subcarrier
//   tx_taps            tap k = prompt delayed k*TAP_SP half-chips
//   tx_tick            new chip presented
//   tx_sop, tx_eop     chip 0 / last chip presented
//   tx_chip_cnt        chip count of tx_chip
//   tx_offset          current code offset
//   tx_epoch           completed code periods
//   tx_acc             phase accumulator
module boc_prn_nco_gen #(
    parameter int ACC_WIDTH = 32,
    parameter int CODE_LEN  = 4092,
    parameter int PHS_WIDTH = 12,
    parameter int BOC_M     = 1,
    parameter int ACQ_STEP  = 4,
    parameter int N_TAP     = 3,
    parameter int TAP_SP    = 2
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst_n,
    input  logic                 rx_en,
    input  logic [ACC_WIDTH-1:0] rx_fcw,
    input  logic                 rx_mode,
    input  logic                 rx_load,
    input  logic [PHS_WIDTH-1:0] rx_start_idx,
    input  logic                 rx_rom_data,
    output logic [PHS_WIDTH-1:0] tx_rom_addr,
    output logic                 tx_chip,
    output logic                 tx_boc,
    output logic [N_TAP-1:0]     tx_taps,
    output logic                 tx_tick,
    output logic                 tx_sop,
    output logic                 tx_eop,
    output logic [PHS_WIDTH-1:0] tx_chip_cnt,
    output logic [PHS_WIDTH-1:0] tx_offset,
    output logic [15:0]          tx_epoch,
    output logic [ACC_WIDTH-1:0] tx_acc
);

    localparam int TAP_DEPTH = (N_TAP - 1) * TAP_SP + 1;
    // Bit toggling 2*BOC_M times per chip period.
    localparam int SUB_BIT = ACC_WIDTH - $clog2(2 * BOC_M);
    localparam logic [PHS_WIDTH:0] LEN_X  = (PHS_WIDTH + 1)'(CODE_LEN);
    localparam logic [PHS_WIDTH:0] LAST_X = (PHS_WIDTH + 1)'(CODE_LEN - 1);
    localparam logic [PHS_WIDTH:0] STEP_X = (PHS_WIDTH + 1)'(ACQ_STEP);

    // Operands are both < CODE_LEN, so one conditional subtract suffices.
    function automatic logic [PHS_WIDTH-1:0] mod_len(input logic [PHS_WIDTH:0] v);
        logic [PHS_WIDTH:0] r;
        r = (v >= LEN_X) ? v - LEN_X : v;
        return r[PHS_WIDTH-1:0];
    endfunction

    // Stage 1: accumulator, counter, offset, ROM address.
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [PHS_WIDTH-1:0] chip_cnt_q, chip_cnt_d;
    logic [PHS_WIDTH-1:0] offset_q, offset_d;
    logic [PHS_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]          epoch_q, epoch_d;
    logic                 tick1_q, tick1_d;
    logic                 htick1_q, htick1_d;
    logic                 sub1_q, sub1_d;
    // Stage 2: chip captured from the ROM, aligned with its count and sub-phase.
    logic                 tick2_q, tick2_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic                 chip_q, chip_d;
    logic [PHS_WIDTH-1:0] cnt2_q, cnt2_d;
    logic                 sub2_q, sub2_d;
    logic [TAP_DEPTH-1:0] taps_q, taps_d;

    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 half_rise;
    logic                 wrap;
    logic [PHS_WIDTH-1:0] ld_off;

    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, rx_fcw};
        carry     = sum[ACC_WIDTH];
        half_rise = ~acc_q[ACC_WIDTH-1] & sum[ACC_WIDTH-1];
        wrap      = carry && ({1'b0, chip_cnt_q} == LAST_X);
        ld_off    = ({1'b0, rx_start_idx} >= LEN_X) ? '0 : rx_start_idx;

        acc_d      = acc_q;
        chip_cnt_d = chip_cnt_q;
        offset_d   = offset_q;
        rom_addr_d = rom_addr_q;
        epoch_d    = epoch_q;
        tick1_d    = tick1_q;
        htick1_d   = htick1_q;
        sub1_d     = sub1_q;
        tick2_d    = tick2_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        chip_d     = chip_q;
        cnt2_d     = cnt2_q;
        sub2_d     = sub2_q;
        taps_d     = taps_q;

        if (rx_en) begin
            tick2_d = tick1_q;
            sop_d   = tick1_q && (chip_cnt_q == '0);
            eop_d   = tick1_q && ({1'b0, chip_cnt_q} == LAST_X);
            sub2_d  = sub1_q;
            if (tick1_q) begin
                chip_d = rx_rom_data;
                cnt2_d = chip_cnt_q;
            end
            if (htick1_q) begin
                taps_d[0] = rx_rom_data;
                for (int i = 1; i < TAP_DEPTH; i++) taps_d[i] = taps_q[i-1];
            end
        end

        if (rx_load) begin
            // A load behaves like a fresh capture of chip 0 so that sop and
            // the prompt tap come out on the usual 2-cycle latency.
            acc_d      = '0;
            chip_cnt_d = '0;
            epoch_d    = '0;
            offset_d   = ld_off;
            rom_addr_d = ld_off;
            tick1_d    = 1'b1;
            htick1_d   = 1'b1;
            sub1_d     = 1'b0;
            taps_d     = '0;
        end else if (rx_en) begin
            acc_d    = sum[ACC_WIDTH-1:0];
            tick1_d  = carry;
            htick1_d = carry | half_rise;
            sub1_d   = sum[SUB_BIT];
            if (carry) begin
                chip_cnt_d = wrap ? '0 : chip_cnt_q + PHS_WIDTH'(1);
                // Offset only moves at the period boundary, never mid-code.
                if (wrap) begin
                    epoch_d = epoch_q + 16'd1;
                    if (rx_mode) offset_d = mod_len({1'b0, offset_q} + STEP_X);
                end
                rom_addr_d = mod_len({1'b0, chip_cnt_d} + {1'b0, offset_d});
            end
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            acc_q      <= '0;
            chip_cnt_q <= '0;
            offset_q   <= '0;
            rom_addr_q <= '0;
            epoch_q    <= '0;
            tick1_q    <= 1'b0;
            htick1_q   <= 1'b0;
            sub1_q     <= 1'b0;
            tick2_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            chip_q     <= 1'b0;
            cnt2_q     <= '0;
            sub2_q     <= 1'b0;
            taps_q     <= '0;
        end else begin
            acc_q      <= acc_d;
            chip_cnt_q <= chip_cnt_d;
            offset_q   <= offset_d;
            rom_addr_q <= rom_addr_d;
            epoch_q    <= epoch_d;
            tick1_q    <= tick1_d;
            htick1_q   <= htick1_d;
            sub1_q     <= sub1_d;
            tick2_q    <= tick2_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            chip_q     <= chip_d;
            cnt2_q     <= cnt2_d;
            sub2_q     <= sub2_d;
            taps_q     <= taps_d;
        end
    end

    always_comb begin
        tx_taps = '0;
        for (int k = 0; k < N_TAP; k++) tx_taps[k] = taps_q[k*TAP_SP];
    end

    assign tx_rom_addr = rom_addr_q;
    assign tx_chip     = chip_q;
    assign tx_boc      = chip_q ^ sub2_q;
    // Event strobes are suppressed while the datapath is frozen.
    assign tx_tick     = tick2_q & rx_en;
    assign tx_sop      = sop_q & rx_en;
    assign tx_eop      = eop_q & rx_en;
    assign tx_chip_cnt = cnt2_q;
    assign tx_offset   = offset_q;
    assign tx_epoch    = epoch_q;
    assign tx_acc      = acc_q;

endmodule

// File: tb/tb_boc_prn_nco_gen.sv
// Bench for boc_prn_nco_gen: expected chip events are queued by the stimulus
// process and checked by a monitor whenever tx_tick is seen; state checks
// (reset, ROM address sequence, BOC/taps, freeze) are made inline.
module tb_boc_prn_nco_gen;
    localparam int L = 4092;

    logic        clk = 1'b0;
    logic        rst_n, en, mode, load, rom_data;
    logic [31:0] fcw;
    logic [11:0] start_idx;
    logic [11:0] rom_addr, chip_cnt, offset;
    logic        chip, boc, tick, sop, eop;
    logic [2:0]  taps;
    logic [15:0] epoch;
    logic [31:0] acc;

    always #5 clk = ~clk;

    // ROM content: parity of the code index.
    assign rom_data = rom_addr[0];

    boc_prn_nco_gen dut (
        .rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en), .rx_fcw(fcw), .rx_mode(mode),
        .rx_load(load), .rx_start_idx(start_idx), .rx_rom_data(rom_data),
        .tx_rom_addr(rom_addr), .tx_chip(chip), .tx_boc(boc), .tx_taps(taps),
        .tx_tick(tick), .tx_sop(sop), .tx_eop(eop), .tx_chip_cnt(chip_cnt),
        .tx_offset(offset), .tx_epoch(epoch), .tx_acc(acc)
    );

    typedef struct {
        int cnt; int chip; int sop; int eop; int ep; int off; int rom; int gap;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_on = 1'b0;
    int   since  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void push_exp(input int cnt, input int off, input int ep, input int gap);
        exp_t e;
        e.cnt = cnt; e.rom = (cnt + off) % L; e.chip = e.rom & 1;
        e.sop = (cnt == 0) ? 1 : 0; e.eop = (cnt == L - 1) ? 1 : 0;
        e.ep = ep; e.off = off; e.gap = gap;
        sbq.push_back(e);
    endfunction

    // Monitor: pops one expected chip per observed tick.
    initial begin : monitor
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            since++;
            if (tick) begin
                if (mon_on) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_tick: got cnt=%0d expected no tick", chip_cnt);
                    end else begin
                        e  = sbq.pop_front();
                        ok = (int'(chip_cnt) == e.cnt) && (int'(chip) == e.chip) &&
                             (int'(sop) == e.sop) && (int'(eop) == e.eop) &&
                             (int'(epoch) == e.ep) && (int'(offset) == e.off) &&
                             (int'(rom_addr) == e.rom);
                        n_chk++;
                        if (ok) n_pass++;
                        else $display("FAIL tick: got cnt=%0d chip=%0d sop=%0d eop=%0d ep=%0d off=%0d rom=%0d expected cnt=%0d chip=%0d sop=%0d eop=%0d ep=%0d off=%0d rom=%0d",
                                      chip_cnt, chip, sop, eop, epoch, offset, rom_addr,
                                      e.cnt, e.chip, e.sop, e.eop, e.ep, e.off, e.rom);
                        if (e.gap != 0) chk("tick_gap", since, e.gap);
                    end
                end
                since = 0;
            end
        end
    end

    task automatic drain(input int budget);
        int i = 0;
        while (sbq.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_chk++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left expected 0", sbq.size());
        mon_on = 1'b0;
        sbq.delete();
    endtask

    // Stop the NCO and let in-flight chips flush out.
    task automatic idle();
        @(posedge clk); #1;
        fcw = '0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int idx, input logic [31:0] f);
        start_idx = 12'(idx); fcw = f; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    initial begin : stim
        int   i;
        logic [2:0] et;
        int   c;
        rst_n = 1'b0; en = 1'b0; fcw = '0; mode = 1'b0; load = 1'b0; start_idx = '0;
        #12;
        chk("rst_acc", acc, 0);       chk("rst_rom", rom_addr, 0);
        chk("rst_chip", chip, 0);     chk("rst_tick", tick, 0);
        chk("rst_epoch", epoch, 0);   chk("rst_offset", offset, 0);
        chk("rst_cnt", chip_cnt, 0);  chk("rst_taps", taps, 0);

        // Track mode from reset, 4 clocks per chip, one full period.
        @(posedge clk); #1;
        for (int k = 1; k < L; k++) push_exp(k, 0, 0, (k == 1) ? 0 : 4);
        push_exp(0, 0, 1, 4);
        push_exp(1, 0, 1, 4);
        mon_on = 1'b1; rst_n = 1'b1; en = 1'b1; fcw = 32'h4000_0000;
        drain(20000);
        chk("p1_epoch", epoch, 1);
        chk("p1_offset", offset, 0);
        idle();

        // Track-mode load near the end of the code: address wraps.
        push_exp(0, 4090, 0, 0); push_exp(1, 4090, 0, 2);
        push_exp(2, 4090, 0, 2); push_exp(3, 4090, 0, 2);
        mon_on = 1'b1;
        do_load(4090, 32'h8000_0000);
        chk("p2_rom0", rom_addr, 4090);
        chk("p2_offset", offset, 4090);
        @(posedge clk); #1;
        chk("p2_sop", sop, 1);
        chk("p2_cnt", chip_cnt, 0);
        @(posedge clk); #1;
        chk("p2_rom1", rom_addr, 4091);
        repeat (2) @(posedge clk);
        #1;
        chk("p2_rom2", rom_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("p2_rom3", rom_addr, 1);
        drain(100);
        idle();

        // Acquisition: offset steps 4090 -> 2 -> 6 at each wrap.
        mode = 1'b1;
        for (int k = 0; k < L; k++) push_exp(k, 4090, 0, (k == 0) ? 0 : 2);
        for (int k = 0; k < L; k++) push_exp(k, 2, 1, 2);
        push_exp(0, 6, 2, 2);
        push_exp(1, 6, 2, 2);
        mon_on = 1'b1;
        do_load(4090, 32'h8000_0000);
        drain(20000);
        chk("p3_offset", offset, 6);
        idle();
        mode = 1'b0;

        // BOC subcarrier and taps, 8 clocks per chip.
        do_load(0, 32'h2000_0000);
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            c = j / 8;
            chk("p4_chip", chip, c & 1);
            chk("p4_boc", boc, (c & 1) ^ (((j % 8) >= 4) ? 1 : 0));
            for (int k = 0; k < 3; k++) et[k] = (c - k >= 0) ? 1'((c - k) & 1) : 1'b0;
            chk("p4_taps", taps, et);
        end
        idle();

        // Load in the same cycle as the carry that would wrap chip 4091.
        do_load(0, 32'h8000_0000);
        i = 0;
        while (!(rom_addr == 12'd4091 && acc == 32'h8000_0000) && i < 9000) begin
            @(posedge clk); #1;
            i++;
        end
        chk("p5_reach_4091", (i < 9000) ? 1 : 0, 1);
        push_exp(L - 1, 0, 0, 0);
        push_exp(0, 0, 0, 2);
        push_exp(1, 0, 0, 0);
        mon_on = 1'b1;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("p5_epoch", epoch, 0);
        chk("p5_no_eop", eop, 0);
        @(posedge clk); #1;
        chk("p5_cnt", chip_cnt, 0);
        @(posedge clk); #1;
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("frz_tick", tick, 0);
            chk("frz_acc", acc, 0);
            chk("frz_rom", rom_addr, 1);
            chk("frz_cnt", chip_cnt, 0);
        end
        en = 1'b1;
        drain(50);
        idle();

        // Reset pulse mid-epoch with a non-zero offset.
        do_load(100, 32'h4000_0000);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_acc", acc, 0);      chk("mrst_offset", offset, 0);
        chk("mrst_rom", rom_addr, 0); chk("mrst_epoch", epoch, 0);
        chk("mrst_cnt", chip_cnt, 0); chk("mrst_chip", chip, 0);
        chk("mrst_taps", taps, 0);    chk("mrst_tick", tick, 0);
        @(posedge clk); #1;
        push_exp(1, 0, 0, 0);
        push_exp(2, 0, 0, 4);
        mon_on = 1'b1;
        rst_n = 1'b1;
        drain(50);
        chk("p6_offset", offset, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
